// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V width codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane logic: request-side mask/shift/legality checks and load-side extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_sh,
    output logic        misalign,
    output logic        illegal,
    output logic [31:0] ld_data
);

    logic [31:0] rd_sh;

    always_comb begin
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr_lo[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr_lo != 2'b00));
        if (req_wen) begin
            illegal = (req_funct3 > F3_W);
        end else begin
            illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111);
        end

        case (req_funct3[1:0])
            2'b00:   mask = 4'b0001 << req_addr_lo;
            2'b01:   mask = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase

        wdata_sh = req_wdata << {req_addr_lo, 3'b000};
    end

    // The addressed byte/half is brought down to bit 0 before extension.
    always_comb begin
        rd_sh = mem_rdata >> {ld_addr_lo, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
            F3_H:    ld_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
            F3_W:    ld_data = rd_sh;
            F3_BU:   ld_data = {24'd0, rd_sh[7:0]};
            F3_HU:   ld_data = {16'd0, rd_sh[15:0]};
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core access at a time, drives an aligned memory handshake,
// returns extended load data or a trap, and aborts accesses that exceed a cycle budget.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wen,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_trap,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_ren,
    output logic                  o_mem_wen,
    output logic [31:0]           o_mem_wdata,
    output logic [3:0]            o_mem_mask,
    input  logic                  i_mem_rvalid,
    input  logic [31:0]           i_mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d;
    logic                  wen_q, wen_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            mask_q, mask_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  trap_q, trap_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [3:0]    al_mask;
    logic [31:0]   al_wdata;
    logic          al_misalign;
    logic          al_illegal;
    logic [31:0]   al_ld_data;
    logic [CW-1:0] cnt_inc;
    logic          timeout;
    logic          mem_act;
    logic          rsp_act;

    lsu_align u_align (
        .req_wen     (i_req_wen),
        .req_funct3  (i_req_funct3),
        .req_addr_lo (i_req_addr[1:0]),
        .req_wdata   (i_req_wdata),
        .ld_funct3   (funct3_q),
        .ld_addr_lo  (addr_q[1:0]),
        .mem_rdata   (i_mem_rdata),
        .mask        (al_mask),
        .wdata_sh    (al_wdata),
        .misalign    (al_misalign),
        .illegal     (al_illegal),
        .ld_data     (al_ld_data)
    );

    assign cnt_inc = cnt_q + 1'b1;
    assign timeout = (cnt_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d  = state_q;
        wen_d    = wen_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        trap_d   = trap_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    wen_d    = i_req_wen;
                    funct3_d = i_req_funct3;
                    addr_d   = i_req_addr;
                    mask_d   = al_mask;
                    wdata_d  = al_wdata;
                    rdata_d  = 32'd0;
                    trap_d   = al_misalign | al_illegal;
                    cnt_d    = '0;
                    state_d  = (al_misalign | al_illegal) ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                if (i_mem_ready) begin
                    state_d = wen_q ? ST_RESP : ST_WAIT;
                end else if (timeout) begin
                    trap_d  = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (i_mem_rvalid) begin
                    rdata_d = al_ld_data;
                    state_d = ST_RESP;
                end else if (timeout) begin
                    trap_d  = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            wen_q    <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            mask_q   <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            trap_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wen_q    <= wen_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            trap_q   <= trap_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for a clock.
    assign mem_act     = (state_q == ST_REQ);
    assign rsp_act     = (state_q == ST_RESP);
    assign o_req_ready = (state_q == ST_IDLE);
    assign o_mem_valid = mem_act;
    assign o_mem_addr  = mem_act ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign o_mem_ren   = mem_act & ~wen_q;
    assign o_mem_wen   = mem_act & wen_q;
    assign o_mem_wdata = mem_act ? wdata_q : 32'd0;
    assign o_mem_mask  = mem_act ? mask_q : 4'd0;
    assign o_rsp_valid = rsp_act;
    assign o_rsp_rdata = rsp_act ? rdata_q : 32'd0;
    assign o_rsp_trap  = rsp_act & trap_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: maximum cycles spent waiting on memory before the access is aborted with a trap; minimum 2.
REQ-002 Parameter ADDR_WIDTH, default 32: width of the core-side and memory-side byte addresses.
REQ-003 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-004 i_rst  in  1  reset, asynchronous and active-high.
REQ-005 i_req_valid  in  1  core presents a load/store request.
REQ-006 o_req_ready  out  1  LSU idle and able to accept a request.
REQ-007 i_req_wen  in  1  1 = store, 0 = load.
REQ-008 i_req_funct3  in  3  RISC-V width code: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
REQ-009 i_req_addr  in  ADDR_WIDTH  unaligned byte address.
REQ-010 i_req_wdata  in  32  store data, right-justified.
REQ-011 o_rsp_valid  out  1  one-cycle completion pulse.
REQ-012 o_rsp_rdata  out  32  load result, extended per funct3; 0 for stores and traps.
REQ-013 o_rsp_trap  out  1  qualified by o_rsp_valid: misaligned, illegal funct3, or timeout.
REQ-014 o_mem_valid  out  1  memory request valid; held until i_mem_ready.
REQ-015 i_mem_ready  in  1  memory accepts the request this cycle.
REQ-016 o_mem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0).
REQ-017 o_mem_ren, o_mem_wen  out  1 each  read/write strobes, mutually exclusive, asserted only with o_mem_valid.
REQ-018 o_mem_wdata  out  32  store data shifted left by 8*addr[1:0].
REQ-019 o_mem_mask  out  4  byte lanes: byte 0001<<addr[1:0]; half 0011 or 1100; word 1111.
REQ-020 i_mem_rvalid  in  1  read data valid; sampled only in WAIT.
REQ-021 i_mem_rdata  in  32  aligned read word.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, WAIT and RESP; o_req_ready=1 only in IDLE.
REQ-023 IDLE: i_req_valid&o_req_ready SHALL register the request; legal and aligned -> REQ; otherwise -> RESP with trap.
REQ-024 Misaligned means a half access with addr[0]=1 or a word access with addr[1:0]!=0; illegal funct3 means 011/110/111 for loads or >010 for stores; neither SHALL assert o_mem_valid.
REQ-025 REQ: o_mem_valid=1 with addr/mask/wdata/strobes stable from registered values; on i_mem_ready, a store SHALL go to RESP and a load to WAIT.
REQ-026 WAIT: on i_mem_rvalid the LSU SHALL register the lane-selected word, shifted right by 8*addr[1:0] and sign/zero-extended per funct3, then go to RESP.
REQ-027 RESP: o_rsp_valid=1 for exactly one cycle, then IDLE; a new request SHALL be acceptable on the cycle after RESP.
REQ-028 Minimum latency, with acceptance at cycle T: trap response T+1; store with ready at T+1 responds T+2; load with ready T+1 and rvalid T+2 responds T+3.
REQ-029 A timeout counter SHALL clear on acceptance, count every cycle in REQ or WAIT, and on reaching TIMEOUT_CYCLES force RESP with trap=1 and rdata=0.
REQ-030 i_mem_rvalid outside WAIT and i_req_valid outside IDLE SHALL be ignored.

Reset
REQ-031 Asserting i_rst SHALL immediately force IDLE, counter 0, o_req_ready=1, and all other outputs 0, including mid-transaction; no response is produced for an aborted access.

Structure
REQ-032 Package lsu_pkg SHALL hold the funct3 width constants and the state enum typedef.
REQ-033 Combinational sub-module lsu_align SHALL compute the mask, the wdata shift, misalign/illegal detection and load extension; lsu holds the FSM, registers and counter.

Verification
REQ-034 LB addr=0x1003, rdata=0x80FF_FF00 (rvalid 1 cycle after ready) -> mask 1000, mem addr 0x1000, rsp rdata 0xFFFF_FF80, trap 0, response at T+3.
REQ-035 SH addr=0x2002, wdata=0x0000_ABCD, ready held low 3 cycles -> o_mem_valid held 4 cycles, mask 1100, wdata 0xABCD_0000, store response the cycle after ready.
REQ-036 LW addr=0x3002 -> no o_mem_valid, o_rsp_valid at T+1 with trap=1; funct3=011 load -> same.
REQ-037 LHU addr=0x4000, rvalid never asserted, TIMEOUT_CYCLES=8 -> response 8 cycles after entering REQ, trap=1, rdata=0.
REQ-038 i_rst pulsed while in WAIT -> outputs cleared asynchronously, no response pulse, next request accepted normally.
